// File: rtl/coeff_loader.sv
// coeff_loader: runtime-writable twiddle-coefficient store for one FFT stage.
// Words arrive over a valid/ready stream into a shadow bank; a frame-boundary
// strobe commits the shadow bank into the active bank that drives coeff_data.
module coeff_loader #(
    parameter int NBITS = 11,
    parameter int N     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [2*NBITS-1:0]     s_data,
    input  logic                   s_last,
    input  logic                   swap_en,
    output logic [NBITS*N*2-1:0]   coeff_data,
    output logic                   coeff_valid,
    output logic                   load_done,
    output logic                   swapped,
    output logic                   err_len
);

    localparam int W  = 2 * NBITS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);
    // Unity real part (1.0 = 2^(NBITS-2)), zero imaginary part.
    localparam logic [NBITS-1:0] ONE_Q    = NBITS'(2 ** (NBITS - 2));
    localparam logic [W-1:0]     RST_WORD = {ONE_Q, {NBITS{1'b0}}};

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          coeff_valid_q, coeff_valid_d;
    logic          swapped_q, swapped_d;
    logic          err_len_q, err_len_d;

    logic [W-1:0]  shadow_q [N];
    logic [W-1:0]  shadow_d [N];
    logic [W-1:0]  active_q [N];
    logic [W-1:0]  active_d [N];

    // Next-state logic: shadow writes while filling, commit to active when full.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        coeff_valid_d = coeff_valid_q;
        swapped_d     = 1'b0;
        err_len_d     = 1'b0;
        shadow_d      = shadow_q;
        active_d      = active_q;

        case (state_q)
            ST_FILL: begin
                // swap_en is deliberately ignored here: a partial bank is never committable.
                if (s_valid) begin
                    shadow_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        // Bank is full either way; a missing s_last is flagged but the set is kept.
                        idx_d     = '0;
                        state_d   = ST_FULL;
                        err_len_d = !s_last;
                    end else if (s_last) begin
                        // Early last: restart the load, shadow contents are left stale.
                        idx_d     = '0;
                        err_len_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (swap_en) begin
                    active_d      = shadow_q;
                    coeff_valid_d = 1'b1;
                    swapped_d     = 1'b1;
                    state_d       = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = '0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            idx_q         <= '0;
            coeff_valid_q <= 1'b0;
            swapped_q     <= 1'b0;
            err_len_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            coeff_valid_q <= coeff_valid_d;
            swapped_q     <= swapped_d;
            err_len_q     <= err_len_d;
        end
    end

    // Per-slot bank registers and output packing; slot 0 lands in the MSB slot.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            // Shadow and active storage for this slot, both reset to unity.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_q[gi] <= RST_WORD;
                    active_q[gi] <= RST_WORD;
                end else begin
                    shadow_q[gi] <= shadow_d[gi];
                    active_q[gi] <= active_d[gi];
                end
            end

            assign coeff_data[(N-gi)*W-1 -: W] = active_q[gi];
        end
    endgenerate

    assign s_ready     = (state_q == ST_FILL);
    assign load_done   = (state_q == ST_FULL);
    assign coeff_valid = coeff_valid_q;
    assign swapped     = swapped_q;
    assign err_len     = err_len_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: accepted words go into a scoreboard
// queue, and each swap pops a full bank that coeff_data is compared against.
module tb_coeff_loader;

    localparam int NBITS = 11;
    localparam int N     = 32;
    localparam int W     = 2 * NBITS;
    localparam logic [W-1:0] R = 22'h100000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [W-1:0]       s_data = '0;
    logic               s_last = 1'b0;
    logic               swap_en = 1'b0;
    logic [N*W-1:0]     coeff_data;
    logic               coeff_valid;
    logic               load_done;
    logic               swapped;
    logic               err_len;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] exp_bank [N];

    coeff_loader #(.NBITS(NBITS), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .swap_en    (swap_en),
        .coeff_data (coeff_data),
        .coeff_valid(coeff_valid),
        .load_done  (load_done),
        .swapped    (swapped),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*W-1:0] pack_exp();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[(N-k)*W-1 -: W] = exp_bank[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word offered on the stream for one edge; valid is left high so
    // consecutive calls give back-to-back traffic.
    task automatic send(input logic [W-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        sb_q.push_back(d);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_swap();
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        if (sb_q.size() == N) begin
            for (int k = 0; k < N; k++) exp_bank[k] = sb_q.pop_front();
        end
        $display("swap: slot0=%06h slot31=%06h coeff_valid=%0b", exp_bank[0], exp_bank[N-1], coeff_valid);
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int k = 0; k < N; k++) exp_bank[k] = R;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL reset_data: got %h want %h", coeff_data, pack_exp()); end
        n_cmp++;
        if (coeff_valid !== 1'b0) begin n_err++; $display("FAIL reset_coeff_valid: got %b want 0", coeff_valid); end
        n_cmp++;
        if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        n_cmp++;
        if (load_done !== 1'b0 || swapped !== 1'b0 || err_len !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got ld=%b sw=%b el=%b want 0 0 0", load_done, swapped, err_len);
        end
    endtask

    task automatic test_full_load();
        for (int k = 0; k < N; k++) send(22'h34AE95, k == N-1);
        idle();
        n_cmp++;
        if (load_done !== 1'b1 || s_ready !== 1'b0) begin n_err++; $display("FAIL full_load_done: got ld=%b rdy=%b want 1 0", load_done, s_ready); end
        tick();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL full_before_swap: got %h want %h", coeff_data, pack_exp()); end
        do_swap();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL full_after_swap: got %h want %h", coeff_data, pack_exp()); end
        n_cmp++;
        if (swapped !== 1'b1 || coeff_valid !== 1'b1 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL full_swap_flags: got sw=%b cv=%b rdy=%b want 1 1 1", swapped, coeff_valid, s_ready);
        end
        tick();
        n_cmp++;
        if (swapped !== 1'b0) begin n_err++; $display("FAIL full_swap_pulse: got %b want 0", swapped); end
    endtask

    task automatic test_ordering();
        for (int k = 0; k < N; k++) send(W'(k), k == N-1);
        idle();
        do_swap();
        n_cmp++;
        if (coeff_data[703:682] !== 22'h000000) begin n_err++; $display("FAIL order_msb: got %h want 000000", coeff_data[703:682]); end
        n_cmp++;
        if (coeff_data[21:0] !== 22'h00001F) begin n_err++; $display("FAIL order_lsb: got %h want 00001f", coeff_data[21:0]); end
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL order_bank: got %h want %h", coeff_data, pack_exp()); end
        tick();
    endtask

    task automatic test_early_last();
        for (int k = 0; k < 10; k++) send(22'h3FFFFF - W'(k), k == 9);
        idle();
        n_cmp++;
        if (err_len !== 1'b1 || load_done !== 1'b0 || s_ready !== 1'b1) begin
            n_err++; $display("FAIL early_last_flags: got el=%b ld=%b rdy=%b want 1 0 1", err_len, load_done, s_ready);
        end
        sb_q.delete();
        tick();
        n_cmp++;
        if (err_len !== 1'b0) begin n_err++; $display("FAIL early_last_pulse: got %b want 0", err_len); end
        for (int k = 0; k < N; k++) send(22'h02A000 + W'(k * 7), k == N-1);
        idle();
        n_cmp++;
        if (load_done !== 1'b1 || err_len !== 1'b0) begin n_err++; $display("FAIL early_reload: got ld=%b el=%b want 1 0", load_done, err_len); end
        do_swap();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL early_commit: got %h want %h", coeff_data, pack_exp()); end
        tick();
    endtask

    task automatic test_missing_last();
        for (int k = 0; k < N; k++) send(22'h155555 ^ W'(k << 3), 1'b0);
        idle();
        n_cmp++;
        if (err_len !== 1'b1 || load_done !== 1'b1) begin n_err++; $display("FAIL missing_last_flags: got el=%b ld=%b want 1 1", err_len, load_done); end
        do_swap();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL missing_last_commit: got %h want %h", coeff_data, pack_exp()); end
        tick();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N; k++) send(W'(k << 8) | W'(k), k == N-1);
        s_data = 22'h3FFFFF;
        s_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (s_ready !== 1'b0 || load_done !== 1'b1) begin
                n_err++; $display("FAIL backpressure_c%0d: got rdy=%b ld=%b want 0 1", c, s_ready, load_done);
            end
        end
        idle();
        do_swap();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL backpressure_commit: got %h want %h", coeff_data, pack_exp()); end
    endtask

    // Starts in the swapped-pulse cycle left by the previous task.
    task automatic test_back_to_back();
        logic [N*W-1:0] held;
        held = pack_exp();
        for (int k = 0; k < N; k++) begin
            send(22'h2B0000 + W'(k * 13), k == N-1);
            if (k < N-1) begin
                n_cmp++;
                if (load_done !== 1'b0) begin n_err++; $display("FAIL b2b_early_done_w%0d: got %b want 0", k, load_done); end
            end
        end
        idle();
        n_cmp++;
        if (load_done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", load_done); end
        n_cmp++;
        if (coeff_data !== held) begin n_err++; $display("FAIL b2b_active_held: got %h want %h", coeff_data, held); end
        do_swap();
        n_cmp++;
        if (coeff_data !== pack_exp()) begin n_err++; $display("FAIL b2b_commit: got %h want %h", coeff_data, pack_exp()); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        for (int k = 0; k < 20; k++) send(22'h0ABCDE + W'(k), 1'b0);
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        n_cmp++;
        if (coeff_data !== pack_exp() || coeff_valid !== 1'b0) begin
            n_err++; $display("FAIL midreset_state: got cv=%b data=%h want cv=0 data=%h", coeff_valid, coeff_data, pack_exp());
        end
        n_cmp++;
        if (s_ready !== 1'b1 || load_done !== 1'b0) begin n_err++; $display("FAIL midreset_flags: got rdy=%b ld=%b want 1 0", s_ready, load_done); end
        swap_en = 1'b1;
        tick();
        swap_en = 1'b0;
        n_cmp++;
        if (swapped !== 1'b0 || coeff_data !== pack_exp() || s_ready !== 1'b1) begin
            n_err++; $display("FAIL midreset_swap_ignored: got sw=%b rdy=%b want 0 1", swapped, s_ready);
        end
        for (int k = 0; k < N; k++) send(22'h200000 | W'(k * 97), k == N-1);
        idle();
        do_swap();
        n_cmp++;
        if (coeff_data !== pack_exp() || coeff_valid !== 1'b1) begin
            n_err++; $display("FAIL midreset_reload: got cv=%b data=%h want cv=1 data=%h", coeff_valid, coeff_data, pack_exp());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_ordering();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
